// File: rtl/cache_ass2vias_pkg.sv
// Shared types and sizes for the 2-set, 2-way write-back cache.
package cache_ass2vias_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 5;
    localparam int SETS   = 2;
    localparam int WAYS   = 2;
    localparam int ADDR_W = TAG_W + 1;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/cache_ass2vias_lookup.sv
// Combinational tag match and victim selection for one set.
module cache_ass2vias_lookup
    import cache_ass2vias_pkg::*;
(
    input  line_t [WAYS-1:0]   i_lines,
    input  logic               i_lru,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_hit,
    output logic               o_hit_way,
    output logic [DATA_W-1:0]  o_hit_data,
    output logic               o_victim_way,
    output line_t              o_victim
);

    logic w_match0;
    logic w_match1;

    always_comb begin
        w_match0   = i_lines[0].valid && (i_lines[0].tag == i_tag);
        w_match1   = i_lines[1].valid && (i_lines[1].tag == i_tag);
        o_hit      = w_match0 || w_match1;
        // way 0 wins when both ways match
        o_hit_way  = !w_match0;
        o_hit_data = i_lines[o_hit_way].data;

        if (!i_lines[0].valid) begin
            o_victim_way = 1'b0;
        end else if (!i_lines[1].valid) begin
            o_victim_way = 1'b1;
        end else begin
            o_victim_way = i_lru;
        end
        o_victim = i_lines[o_victim_way];
    end

endmodule

// File: rtl/cache_ass2vias.sv
// 2-set x 2-way cache, write-allocate / write-back, one-cycle fill from ramlpm.
//   state | meaning
//   IDLE  | sample a request every edge; read miss moves to FILL
//   FILL  | load victim with M_Block_C, drop this edge's request, back to IDLE
module cache_ass2vias
    import cache_ass2vias_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] Address,
    input  logic              Write,
    input  logic [DATA_W-1:0] BlockIn,
    input  logic [DATA_W-1:0] M_Block_C,
    output logic [DATA_W-1:0] BlockOut,
    output logic              C_Write_M,
    output logic [DATA_W-1:0] C_Block_M,
    output logic [ADDR_W-1:0] C_Addr_M,
    output logic              hit
);

    state_t            r_state;
    state_t            w_state_next;

    logic              r_valid [SETS][WAYS];
    logic              r_dirty [SETS][WAYS];
    logic              r_lru   [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];

    logic              r_miss_set;
    logic              r_miss_way;
    logic [TAG_W-1:0]  r_miss_tag;

    logic              w_set;
    logic [TAG_W-1:0]  w_tag;
    line_t [WAYS-1:0]  w_lines;
    logic              w_hit;
    logic              w_hit_way;
    logic [DATA_W-1:0] w_hit_data;
    logic              w_victim_way;
    line_t             w_victim;

    logic              w_upd_line;
    logic              w_upd_set;
    logic              w_upd_way;
    logic              w_upd_dirty;
    logic [TAG_W-1:0]  w_upd_tag;
    logic [DATA_W-1:0] w_upd_data;
    logic              w_touch;
    logic              w_wb;
    logic              w_bo_load;
    logic [DATA_W-1:0] w_bo_val;
    logic              w_hit_nxt;
    logic              w_miss_capture;

    assign w_set = Address[ADDR_W-1];
    assign w_tag = Address[TAG_W-1:0];

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_lines[w].valid = r_valid[w_set][w];
            w_lines[w].dirty = r_dirty[w_set][w];
            w_lines[w].tag   = r_tag[w_set][w];
            w_lines[w].data  = r_data[w_set][w];
        end
    end

    cache_ass2vias_lookup u_lookup (
        .i_lines      (w_lines),
        .i_lru        (r_lru[w_set]),
        .i_tag        (w_tag),
        .o_hit        (w_hit),
        .o_hit_way    (w_hit_way),
        .o_hit_data   (w_hit_data),
        .o_victim_way (w_victim_way),
        .o_victim     (w_victim)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_upd_line     = 1'b0;
        w_upd_set      = w_set;
        w_upd_way      = w_hit_way;
        w_upd_dirty    = 1'b0;
        w_upd_tag      = w_tag;
        w_upd_data     = BlockIn;
        w_touch        = 1'b0;
        w_wb           = 1'b0;
        w_bo_load      = 1'b0;
        w_bo_val       = M_Block_C;
        w_hit_nxt      = 1'b0;
        w_miss_capture = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_hit_nxt = 1'b1;
                    w_touch   = 1'b1;
                    if (Write) begin
                        w_upd_line  = 1'b1;
                        w_upd_dirty = 1'b1;
                    end else begin
                        w_bo_load = 1'b1;
                        w_bo_val  = w_hit_data;
                    end
                end else begin
                    w_upd_way = w_victim_way;
                    w_wb      = w_victim.valid && w_victim.dirty;
                    if (Write) begin
                        w_upd_line  = 1'b1;
                        w_upd_dirty = 1'b1;
                        w_touch     = 1'b1;
                    end else begin
                        w_miss_capture = 1'b1;
                        w_state_next   = FILL;
                    end
                end
            end
            FILL: begin
                // request sampled on this edge is dropped
                w_upd_line   = 1'b1;
                w_upd_set    = r_miss_set;
                w_upd_way    = r_miss_way;
                w_upd_tag    = r_miss_tag;
                w_upd_data   = M_Block_C;
                w_touch      = 1'b1;
                w_bo_load    = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) begin
                r_lru[s] <= 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                end
            end
            BlockOut  <= '0;
            C_Write_M <= 1'b0;
            C_Block_M <= '0;
            C_Addr_M  <= '0;
            hit       <= 1'b0;
        end else begin
            if (w_upd_line) begin
                r_valid[w_upd_set][w_upd_way] <= 1'b1;
                r_dirty[w_upd_set][w_upd_way] <= w_upd_dirty;
            end
            if (w_touch) begin
                r_lru[w_upd_set] <= !w_upd_way;
            end
            hit       <= w_hit_nxt;
            C_Write_M <= w_wb;
            if (w_wb) begin
                C_Block_M <= w_victim.data;
                C_Addr_M  <= {w_set, w_victim.tag};
            end
            if (w_bo_load) begin
                BlockOut <= w_bo_val;
            end
        end
    end

    // Tag/data arrays and the pending-miss record carry no reset.
    always_ff @(posedge clock) begin
        if (w_upd_line) begin
            r_tag[w_upd_set][w_upd_way]  <= w_upd_tag;
            r_data[w_upd_set][w_upd_way] <= w_upd_data;
        end
        if (w_miss_capture) begin
            r_miss_set <= w_set;
            r_miss_way <= w_victim_way;
            r_miss_tag <= w_tag;
        end
    end

endmodule

// File: tb/tb_cache_ass2vias.sv
// Scoreboard bench: directed scenarios plus random traffic against a behavioural cache model.
module tb_cache_ass2vias;

    logic       clock = 1'b0;
    logic       resetn;
    logic [4:0] Address;
    logic       Write;
    logic [4:0] BlockIn;
    logic [4:0] M_Block_C;
    logic [4:0] BlockOut;
    logic       C_Write_M;
    logic [4:0] C_Block_M;
    logic [4:0] C_Addr_M;
    logic       hit;

    always #5 clock = ~clock;

    cache_ass2vias dut (
        .clock     (clock),
        .resetn    (resetn),
        .Address   (Address),
        .Write     (Write),
        .BlockIn   (BlockIn),
        .M_Block_C (M_Block_C),
        .BlockOut  (BlockOut),
        .C_Write_M (C_Write_M),
        .C_Block_M (C_Block_M),
        .C_Addr_M  (C_Addr_M),
        .hit       (hit)
    );

    typedef struct {
        logic       hit;
        logic [4:0] bo;
        logic       cw;
        logic [4:0] cb;
        logic [4:0] ca;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    // reference model: per-set lines plus most-recently-used way, and backing memory
    bit         m_v   [2][2];
    bit         m_d   [2][2];
    logic [3:0] m_t   [2][2];
    logic [4:0] m_dat [2][2];
    int         m_mru [2];
    bit         m_fill;
    logic       m_fs;
    int         m_fw;
    logic [3:0] m_ft;
    exp_t       m_out;
    logic [4:0] mem [32];

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_mru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_v[s][w] = 0;
                m_d[s][w] = 0;
            end
        end
        m_fill = 0;
        m_out  = '{hit: 1'b0, bo: 5'h0, cw: 1'b0, cb: 5'h0, ca: 5'h0};
    endtask

    task automatic model_step(input bit wr, input logic [4:0] a, input logic [4:0] din);
        logic       s;
        logic [3:0] t;
        int         w;
        int         v;
        m_out.cw = 1'b0;
        if (m_fill) begin
            m_v[m_fs][m_fw]   = 1;
            m_d[m_fs][m_fw]   = 0;
            m_t[m_fs][m_fw]   = m_ft;
            m_dat[m_fs][m_fw] = mem[{m_fs, m_ft}];
            m_out.bo          = mem[{m_fs, m_ft}];
            m_out.hit         = 1'b0;
            m_mru[m_fs]       = m_fw;
            m_fill            = 0;
        end else begin
            s = a[4];
            t = a[3:0];
            w = -1;
            for (int i = 1; i >= 0; i--)
                if (m_v[s][i] && m_t[s][i] == t) w = i;
            if (w >= 0) begin
                m_mru[s]  = w;
                m_out.hit = 1'b1;
                if (wr) begin
                    m_dat[s][w] = din;
                    m_d[s][w]   = 1;
                end else begin
                    m_out.bo = m_dat[s][w];
                end
            end else begin
                m_out.hit = 1'b0;
                if (!m_v[s][0])      v = 0;
                else if (!m_v[s][1]) v = 1;
                else                 v = 1 - m_mru[s];
                if (m_v[s][v] && m_d[s][v]) begin
                    m_out.cw = 1'b1;
                    m_out.cb = m_dat[s][v];
                    m_out.ca = {s, m_t[s][v]};
                    mem[{s, m_t[s][v]}] = m_dat[s][v];
                end
                if (wr) begin
                    m_v[s][v]   = 1;
                    m_d[s][v]   = 1;
                    m_t[s][v]   = t;
                    m_dat[s][v] = din;
                    m_mru[s]    = v;
                end else begin
                    m_fill = 1;
                    m_fs   = s;
                    m_fw   = v;
                    m_ft   = t;
                end
            end
        end
        sb.push_back(m_out);
    endtask

    // one clock of stimulus; returns 1 time unit after the edge
    task automatic cyc(input bit wr, input logic [4:0] a, input logic [4:0] din);
        Write   = wr;
        Address = a;
        BlockIn = din;
        @(posedge clock);
        model_step(wr, a, din);
        #1;
        M_Block_C = mem[a];
    endtask

    task automatic op(input bit wr, input logic [4:0] a, input logic [4:0] din);
        cyc(wr, a, din);
        if (m_fill) cyc(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        #2;
        chk("rst_hit", {4'b0, hit}, 5'h0);
        chk("rst_BlockOut", BlockOut, 5'h0);
        chk("rst_C_Write_M", {4'b0, C_Write_M}, 5'h0);
        chk("rst_C_Block_M", C_Block_M, 5'h0);
        chk("rst_C_Addr_M", C_Addr_M, 5'h0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // monitor: every edge the DUT presents a new registered response
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("sb_hit", {4'b0, hit}, {4'b0, mon_e.hit});
                chk("sb_BlockOut", BlockOut, mon_e.bo);
                chk("sb_C_Write_M", {4'b0, C_Write_M}, {4'b0, mon_e.cw});
                chk("sb_C_Block_M", C_Block_M, mon_e.cb);
                chk("sb_C_Addr_M", C_Addr_M, mon_e.ca);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        Address   = '0;
        Write     = 1'b0;
        BlockIn   = '0;
        M_Block_C = '0;
        for (int i = 0; i < 32; i++) mem[i] = 5'($urandom);
        mem[5'h03] = 5'h11;
        model_reset();
        do_reset();

        // read miss, fill, re-read; the write presented during FILL is ignored
        cyc(0, 5'h03, 5'h00);
        chk("r030_miss_hit", {4'b0, hit}, 5'h0);
        chk("r030_miss_cw", {4'b0, C_Write_M}, 5'h0);
        cyc(1, 5'h03, 5'h1F);
        chk("r030_fill_bo", BlockOut, 5'h11);
        cyc(0, 5'h03, 5'h00);
        chk("r030_reread_hit", {4'b0, hit}, 5'h1);
        chk("r030_reread_bo", BlockOut, 5'h11);

        // write-allocate
        do_reset();
        cyc(1, 5'h05, 5'h1A);
        chk("r031_wr_hit", {4'b0, hit}, 5'h0);
        chk("r031_wr_cw", {4'b0, C_Write_M}, 5'h0);
        cyc(0, 5'h05, 5'h00);
        chk("r031_rd_hit", {4'b0, hit}, 5'h1);
        chk("r031_rd_bo", BlockOut, 5'h1A);

        // dirty eviction of the LRU way, then the strobe drops and data holds
        do_reset();
        cyc(1, 5'h01, 5'h07);
        cyc(1, 5'h02, 5'h08);
        op(0, 5'h01, 5'h00);
        cyc(1, 5'h04, 5'h09);
        chk("r032_cw", {4'b0, C_Write_M}, 5'h1);
        chk("r032_cb", C_Block_M, 5'h08);
        chk("r032_ca", C_Addr_M, 5'h02);
        cyc(0, 5'h01, 5'h00);
        chk("r032_cw_pulse", {4'b0, C_Write_M}, 5'h0);
        chk("r032_cb_hold", C_Block_M, 5'h08);
        chk("r032_bo_hold", BlockOut, 5'h07);

        // set isolation
        do_reset();
        cyc(1, 5'h13, 5'h0F);
        cyc(0, 5'h03, 5'h00);
        chk("r033_miss_hit", {4'b0, hit}, 5'h0);
        chk("r033_miss_cw", {4'b0, C_Write_M}, 5'h0);
        cyc(0, 5'h00, 5'h00);
        cyc(0, 5'h13, 5'h00);
        chk("r033_set1_hit", {4'b0, hit}, 5'h1);
        chk("r033_set1_bo", BlockOut, 5'h0F);

        // LRU: A, B, A, C evicts B
        do_reset();
        op(0, 5'h01, 5'h00);
        op(0, 5'h02, 5'h00);
        op(0, 5'h01, 5'h00);
        chk("r035_a_hit", {4'b0, hit}, 5'h1);
        op(0, 5'h03, 5'h00);
        cyc(0, 5'h01, 5'h00);
        chk("r035_a_again_hit", {4'b0, hit}, 5'h1);
        cyc(0, 5'h02, 5'h00);
        chk("r035_b_evicted", {4'b0, hit}, 5'h0);
        cyc(0, 5'h00, 5'h00);

        // reset while in FILL abandons the fill
        do_reset();
        cyc(0, 5'h0A, 5'h00);
        do_reset();
        cyc(0, 5'h0A, 5'h00);
        chk("r034_after_rst_hit", {4'b0, hit}, 5'h0);
        cyc(0, 5'h00, 5'h00);

        // random traffic over a small tag pool so hits, evictions and write-backs all occur
        for (int n = 0; n < 500; n++)
            op(1'($urandom_range(0, 1)),
               {1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))},
               5'($urandom));

        repeat (2) @(posedge clock);
        #2;
        chk("sb_drained", 5'(sb.size()), 5'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
